// File: rtl/slice_stream_ctrl_if.sv
// Handshake and memory-control bundle between slice_stream_ctrl and its consumer.
// The master modport is the controller side; the slave modport is the consumer side.
interface slice_stream_ctrl_if;
  logic       start;
  logic       abort;
  logic       read_file;
  logic [9:0] file_index;
  logic [5:0] line_index;
  logic       slice_valid;
  logic       slice_last;
  logic       slice_ready;
  logic       file_ack;
  logic       busy;
  logic       done;

  modport master (
    input  start, abort, slice_ready, file_ack,
    output read_file, file_index, line_index, slice_valid, slice_last, busy, done
  );

  modport slave (
    output start, abort, slice_ready, file_ack,
    input  read_file, file_index, line_index, slice_valid, slice_last, busy, done
  );
endinterface

// File: rtl/slice_stream_ctrl.sv
// Sweeps files FIRST_FILE..FIRST_FILE+NUM_FILES-1: one load strobe per file, then streams
// its lines over valid/ready and waits for a per-file acknowledge before moving on.
module slice_stream_ctrl #(
  parameter int unsigned FIRST_FILE = 0,
  parameter int unsigned NUM_FILES  = 16,
  parameter int unsigned LINES      = 64
) (
  input  logic                clk,
  input  logic                rst,
  slice_stream_ctrl_if.master bus
);

  localparam logic [9:0] LAST_FILE  = 10'(FIRST_FILE + NUM_FILES - 1);
  localparam logic [9:0] FIRST_IDX  = 10'(FIRST_FILE);
  localparam logic [5:0] LAST_LINE  = 6'(LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] file_q,  file_d;
  logic [5:0] line_q,  line_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      file_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      file_q  <= file_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    file_d  = file_q;
    line_d  = line_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      line_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_LOAD;
            file_d  = FIRST_IDX;
            line_d  = '0;
          end
        end
        S_LOAD:   state_d = S_STREAM;
        S_STREAM: begin
          if (bus.slice_ready) begin
            line_d = line_q + 6'd1;
            if (line_q == LAST_LINE) begin
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (bus.file_ack) begin
            if (file_q == LAST_FILE) begin
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
              file_d  = file_q + 10'd1;
            end
          end
        end
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so ready/ack never reach them combinationally.
  assign bus.read_file   = (state_q == S_LOAD);
  assign bus.slice_valid = (state_q == S_STREAM);
  assign bus.slice_last  = (state_q == S_STREAM) && (line_q == LAST_LINE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.file_index  = file_q;
  assign bus.line_index  = line_q;

endmodule

// File: tb/tb_slice_stream_ctrl.sv
// Bench for slice_stream_ctrl: vector table, directed corner sequences and random sweeps
// compared every cycle against a per-file position model plus an in-order line scoreboard.
module tb_slice_stream_ctrl;
  localparam int FF    = 5;
  localparam int NF    = 2;
  localparam int LINES = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slice_stream_ctrl_if bif ();

  slice_stream_ctrl #(.FIRST_FILE(FF), .NUM_FILES(NF), .LINES(LINES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int errors = 0;
  int checks = 0;

  // Model: pos 0 = load cycle, 1..LINES = presenting line pos-1, LINES+1 = awaiting ack.
  bit m_active, m_done;
  int m_pos, m_ofs, m_file;
  int sb_file, sb_line, xfers;

  typedef struct {
    bit          st, ab, rd, ak;
    logic [20:0] exp;
  } vec_t;
  vec_t tbl[11];

  function automatic logic [20:0] mk(bit b, bit rf, bit v, bit l, bit d, int f, int ln);
    return {b, rf, v, l, d, 10'(f), 6'(ln)};
  endfunction

  function automatic logic [20:0] model_vec();
    bit v;
    v = m_active && m_pos >= 1 && m_pos <= LINES;
    return mk(m_active || m_done, m_active && m_pos == 0, v, v && m_pos == LINES, m_done,
              m_file, v ? m_pos - 1 : 0);
  endfunction

  function automatic logic [20:0] dut_vec();
    return {bif.busy, bif.read_file, bif.slice_valid, bif.slice_last, bif.done,
            bif.file_index, bif.line_index};
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (busy,rf,valid,last,done,file,line)", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_pos = 0; m_ofs = 0; m_file = 0;
  endtask

  task automatic model_step(input bit st, input bit ab, input bit rd, input bit ak);
    if (ab) begin
      m_active = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1; m_pos = 0; m_ofs = 0; m_file = FF; sb_file = FF; sb_line = 0;
      end
    end else if (m_pos == 0) begin
      m_pos = 1;
    end else if (m_pos <= LINES) begin
      if (rd) m_pos++;
    end else if (ak) begin
      if (m_ofs == NF - 1) begin
        m_active = 0; m_done = 1;
      end else begin
        m_ofs++; m_file++; m_pos = 0;
      end
    end
  endtask

  task automatic cyc(input bit st, input bit ab, input bit rd, input bit ak);
    bif.start = st; bif.abort = ab; bif.slice_ready = rd; bif.file_ack = ak;
    if (bif.slice_valid && rd && !ab) begin
      check("line_order", {5'd0, bif.file_index, bif.line_index},
            {5'd0, 10'(sb_file), 6'(sb_line)});
      xfers++;
      sb_line++;
      if (sb_line == LINES) begin sb_line = 0; sb_file++; end
    end
    @(posedge clk);
    model_step(st, ab, rd, ak);
    #1;
    check("cycle", dut_vec(), model_vec());
  endtask

  task automatic adv(input bit rd, input bit ak, input int pos, input int ofs);
    int n = 0;
    while (!(m_active && m_pos == pos && m_ofs == ofs) && n < 1000) begin
      cyc(0, 0, rd, ak);
      n++;
    end
    check("adv_timeout", 21'(n < 1000), 21'd1);
  endtask

  initial begin
    int n, rf_cnt, dn_cnt;
    logic [9:0] rf_f[2];

    rst = 1'b1;
    bif.start = 0; bif.abort = 0; bif.slice_ready = 0; bif.file_ack = 0;
    sb_file = 0; sb_line = 0; xfers = 0;
    model_reset();
    #12;
    check("reset_values", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Table of single-cycle vectors from idle just after reset.
    tbl[0]  = '{0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1, 0, 0, 0, mk(1, 1, 0, 0, 0, 5, 0)};
    tbl[3]  = '{0, 0, 0, 0, mk(1, 0, 1, 0, 0, 5, 0)};
    tbl[4]  = '{0, 0, 0, 0, mk(1, 0, 1, 0, 0, 5, 0)};
    tbl[5]  = '{0, 0, 1, 0, mk(1, 0, 1, 0, 0, 5, 1)};
    tbl[6]  = '{1, 0, 1, 0, mk(1, 0, 1, 0, 0, 5, 2)};
    tbl[7]  = '{0, 0, 1, 1, mk(1, 0, 1, 0, 0, 5, 3)};
    tbl[8]  = '{0, 1, 1, 0, mk(0, 0, 0, 0, 0, 5, 0)};
    tbl[9]  = '{1, 0, 0, 0, mk(1, 1, 0, 0, 0, 5, 0)};
    tbl[10] = '{0, 1, 0, 0, mk(0, 0, 0, 0, 0, 5, 0)};
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].st, tbl[i].ab, tbl[i].rd, tbl[i].ak);
      check($sformatf("table_%0d", i), dut_vec(), tbl[i].exp);
    end

    // Full sweep with ready and ack held high: latency, load strobes, single done.
    cyc(1, 0, 1, 1);
    n = 1; rf_cnt = 0; dn_cnt = 0;
    rf_f[0] = '0; rf_f[1] = '0;
    if (bif.read_file) begin rf_f[0] = bif.file_index; rf_cnt = 1; end
    while (!bif.done && n < 400) begin
      cyc(0, 0, 1, 1);
      n++;
      if (bif.read_file) begin
        if (rf_cnt < 2) rf_f[rf_cnt] = bif.file_index;
        rf_cnt++;
      end
    end
    check("sweep_latency", 21'(n), 21'd133);
    check("load_strobes", {1'b0, 10'(rf_cnt), rf_f[0]}, {1'b0, 10'd2, 10'd5});
    check("second_load", {11'd0, rf_f[1]}, {11'd0, 10'd6});
    for (int i = 0; i < 5; i++) begin
      if (bif.done) dn_cnt++;
      cyc(0, 0, 1, 1);
    end
    check("done_once", 21'(dn_cnt), 21'd1);

    // Ack withheld for 10 cycles after the last slice of file 5.
    cyc(1, 0, 1, 0);
    adv(1, 0, LINES + 1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 0);
      check("drain_hold", {18'd0, bif.busy, bif.read_file, bif.slice_valid}, 21'b100);
    end
    cyc(0, 0, 1, 1);
    check("load_after_ack", {9'd0, bif.read_file, bif.slice_valid, bif.file_index},
          {9'd0, 1'b1, 1'b0, 10'd6});
    cyc(0, 1, 0, 0);

    // Abort (with a simultaneous start) in LOAD, STREAM line 40 and DRAIN.
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0);
      if (k == 1) adv(1, 0, 41, 0);
      if (k == 2) adv(1, 0, LINES + 1, 0);
      cyc(1, 1, 1, 1);
      check($sformatf("abort_%0d", k),
            {11'd0, bif.busy, bif.read_file, bif.slice_valid, bif.done, bif.line_index}, 21'd0);
      dn_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        cyc(0, 0, 1, 1);
        if (bif.done) dn_cnt++;
      end
      check($sformatf("abort_nodone_%0d", k), 21'(dn_cnt), 21'd0);
    end

    // Random ready/ack with stray start pulses while busy.
    for (int s = 0; s < 3; s++) begin
      xfers = 0;
      cyc(1, 0, 0, 0);
      n = 0;
      while ((m_active || m_done) && n < 3000) begin
        cyc(($urandom % 8) == 0, 0, ($urandom % 3) != 0, ($urandom % 4) == 0);
        n++;
      end
      check($sformatf("rand_timeout_%0d", s), 21'(n < 3000), 21'd1);
      check($sformatf("rand_xfers_%0d", s), 21'(xfers), 21'(NF * LINES));
      cyc(0, 0, 0, 0);
    end

    // Asynchronous reset in the middle of file 6, line 20.
    cyc(1, 0, 1, 1);
    adv(1, 1, 21, 1);
    check("pre_reset_pos", {5'd0, bif.file_index, bif.line_index}, {5'd0, 10'd6, 6'd20});
    #2 rst = 1'b1;
    #1 check("async_reset", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0));
    bif.start = 1'b1;
    @(posedge clk); #1;
    check("reset_no_load", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    bif.start = 1'b0;
    model_reset();
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 1);
    check("restart", dut_vec(), mk(1, 1, 0, 0, 0, 5, 0));
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
